// File: rtl/branch_pc_unit.sv
// PC sequencer behind the EX branch comparator: predicts not-taken, redirects and flushes on taken.
// Latency: 1 edge from taken to o_pc=target; i_stall holds the PC in RUN but never extends a flush.
module branch_pc_unit #(
    parameter int          XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_stall,
    input  logic            i_br_valid,
    input  logic            i_taken,
    input  logic [XLEN-1:0] i_br_pc,
    input  logic [XLEN-1:0] i_br_imm,
    output logic [XLEN-1:0] o_pc,
    output logic            o_fetch_valid,
    output logic            o_flush,
    output logic            o_misalign,
    output logic [CNT_W-1:0] o_taken_cnt
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          state;
    logic [FC_W-1:0] flush_cnt;
    logic [XLEN-1:0] target;
    logic            redirect;

    assign target   = i_br_pc + i_br_imm;
    assign redirect = i_br_valid & i_taken;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_BOOT;
            flush_cnt     <= '0;
            o_pc          <= RESET_PC;
            o_fetch_valid <= 1'b0;
            o_flush       <= 1'b0;
            o_misalign    <= 1'b0;
            o_taken_cnt   <= '0;
        end else begin
            o_misalign <= 1'b0;
            case (state)
                ST_BOOT: begin
                    state         <= ST_RUN;
                    o_fetch_valid <= 1'b1;
                end
                ST_RUN: begin
                    // A resolved taken branch outranks a stall: the fetch stream is already wrong.
                    if (redirect) begin
                        state         <= ST_FLUSH;
                        flush_cnt     <= FC_LOAD;
                        o_pc          <= {target[XLEN-1:2], 2'b00};
                        o_flush       <= 1'b1;
                        o_fetch_valid <= 1'b0;
                        o_misalign    <= |target[1:0];
                        o_taken_cnt   <= o_taken_cnt + CNT_W'(1);
                    end else if (!i_stall) begin
                        o_pc <= o_pc + XLEN'(4);
                    end
                end
                ST_FLUSH: begin
                    // Branches seen here are on the wrong path and are dropped.
                    if (flush_cnt == '0) begin
                        state         <= ST_RUN;
                        o_flush       <= 1'b0;
                        o_fetch_valid <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - FC_W'(1);
                    end
                end
                default: begin
                    state         <= ST_BOOT;
                    o_flush       <= 1'b0;
                    o_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
